// File: rtl/i2c_slave_addr_frontend_if.sv
// ---------------------------------------------------------------------------
// i2c_slave_addr_frontend_if
//   Bundles the raw I2C pins, the Data In controller done pulse and every
//   conditioned/control output of the address front end.
//
//   slave  modport : view of the front end itself (pins in, controls out)
//   master modport : view of whoever drives the pins and consumes the outputs
//
//   Signals:
//     SCL_in, SDA_in    raw bus pins
//     data_done         one-cycle done pulse from the Data In controller
//     SCL, SDA          filtered pins;  SCL_prev, SDA_prev  one cycle older
//     enable            write-data phase active
//     rw                captured R/W bit (1 = read)
//     addr_match        one-cycle pulse on own-address match
//     start_det/stop_det one-cycle START / STOP pulses
//     SDA_down          request to pull SDA low (address ACK)
//     bus_busy          bus owned between START and STOP
//     state_dbg         current FSM state encoding
// ---------------------------------------------------------------------------
interface i2c_slave_addr_frontend_if;
    logic       SCL_in;
    logic       SDA_in;
    logic       data_done;
    logic       SCL;
    logic       SCL_prev;
    logic       SDA;
    logic       SDA_prev;
    logic       enable;
    logic       rw;
    logic       addr_match;
    logic       start_det;
    logic       stop_det;
    logic       SDA_down;
    logic       bus_busy;
    logic [2:0] state_dbg;

    modport slave (
        input  SCL_in, SDA_in, data_done,
        output SCL, SCL_prev, SDA, SDA_prev, enable, rw, addr_match,
               start_det, stop_det, SDA_down, bus_busy, state_dbg
    );

    modport master (
        output SCL_in, SDA_in, data_done,
        input  SCL, SCL_prev, SDA, SDA_prev, enable, rw, addr_match,
               start_det, stop_det, SDA_down, bus_busy, state_dbg
    );
endinterface

// File: rtl/i2c_slave_addr_frontend.sv
// ---------------------------------------------------------------------------
// i2c_slave_addr_frontend
//   Upstream stage of the slave Data In controller. Synchronises and
//   glitch-filters SCL/SDA, detects START/STOP, shifts in the address byte,
//   compares it with SLAVE_ADDR and requests the address ACK. After a write
//   address is acknowledged, `enable` hands the conditioned bus to the
//   Data In controller.
//
//   Ports:
//     FPGA_clk  system clock (rising edge)
//     rst       asynchronous, active-low reset
//     bus       i2c_slave_addr_frontend_if.slave (pins, data_done, outputs)
//
//   Handshake with the Data In controller: `enable` is a level that stays
//   high for the whole write-data phase; `data_done` is a single-cycle pulse
//   that is only acted on while in ACTIVE and returns the FSM to IDLE
//   (bus_busy stays high until the STOP is seen).
// ---------------------------------------------------------------------------
module i2c_slave_addr_frontend #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILTER_LEN  = 3
) (
    input  logic                        FPGA_clk,
    input  logic                        rst,
    i2c_slave_addr_frontend_if.slave    bus
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        ACK    = 3'd2,
        ACTIVE = 3'd3,
        IGNORE = 3'd4
    } state_t;

    // ---- conditioning: index 0 = SCL, index 1 = SDA ----
    logic [1:0]             pin_raw;
    logic [SYNC_STAGES-1:0] sync_q [2];
    logic [CNT_W-1:0]       cnt_q  [2];
    logic [1:0]             filt_q;
    logic [1:0]             prev_q;

    assign pin_raw = {bus.SDA_in, bus.SCL_in};

    // The filter only moves after the synchronised level has disagreed with
    // it for FILTER_LEN consecutive cycles; any agreeing sample restarts it.
    always_ff @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= '1;
                cnt_q[i]  <= '0;
            end
            filt_q <= 2'b11;
            prev_q <= 2'b11;
        end else begin
            for (int i = 0; i < 2; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pin_raw[i]};
                if (sync_q[i][SYNC_STAGES-1] != filt_q[i]) begin
                    if (cnt_q[i] == CNT_W'(FILTER_LEN - 1)) begin
                        filt_q[i] <= ~filt_q[i];
                        cnt_q[i]  <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
            prev_q <= filt_q;
        end
    end

    logic scl, scl_p, sda, sda_p;
    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl      = filt_q[0];
    assign sda      = filt_q[1];
    assign scl_p    = prev_q[0];
    assign sda_p    = prev_q[1];
    assign scl_rise = scl & ~scl_p;
    assign scl_fall = ~scl & scl_p;
    assign start_c  = scl & scl_p & ~sda & sda_p;
    assign stop_c   = scl & scl_p & sda & ~sda_p;

    // ---- protocol FSM ----
    state_t     state_q;
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;    // address bits only; the 8th bit goes straight to rw
    logic       byte_full_q; // all 8 bits in, waiting for the 8th SCL fall
    logic       match_q;
    logic       enable_q, rw_q, addr_match_q, start_det_q, stop_det_q;
    logic       sda_down_q, bus_busy_q;

    always_ff @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_full_q  <= 1'b0;
            match_q      <= 1'b0;
            enable_q     <= 1'b0;
            rw_q         <= 1'b0;
            addr_match_q <= 1'b0;
            start_det_q  <= 1'b0;
            stop_det_q   <= 1'b0;
            sda_down_q   <= 1'b0;
            bus_busy_q   <= 1'b0;
        end else begin
            start_det_q  <= start_c;
            stop_det_q   <= stop_c;
            addr_match_q <= 1'b0;

            // STOP outranks START in case both ever show up together.
            if (stop_c) begin
                state_q     <= IDLE;
                bus_busy_q  <= 1'b0;
                enable_q    <= 1'b0;
                sda_down_q  <= 1'b0;
                byte_full_q <= 1'b0;
            end else if (start_c) begin
                state_q     <= ADDR;
                bus_busy_q  <= 1'b1;
                enable_q    <= 1'b0;
                sda_down_q  <= 1'b0;
                rw_q        <= 1'b0;
                bit_cnt_q   <= '0;
                shift_q     <= '0;
                byte_full_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                    ADDR: begin
                        if (scl_rise && !byte_full_q) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7) begin
                                rw_q        <= sda;
                                match_q     <= (shift_q == SLAVE_ADDR);
                                byte_full_q <= 1'b1;
                            end else begin
                                shift_q <= {shift_q[5:0], sda};
                            end
                        end else if (scl_fall && byte_full_q) begin
                            byte_full_q <= 1'b0;
                            if (match_q) begin
                                addr_match_q <= 1'b1;
                                sda_down_q   <= 1'b1;
                                state_q      <= ACK;
                            end else begin
                                sda_down_q <= 1'b0;
                                state_q    <= IGNORE;
                            end
                        end
                    end
                    ACK: begin
                        // Entered on the 8th fall, so the next fall ends the ACK bit.
                        if (scl_fall) begin
                            sda_down_q <= 1'b0;
                            enable_q   <= ~rw_q;
                            state_q    <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (bus.data_done) begin
                            enable_q <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                    IGNORE: begin
                        enable_q   <= 1'b0;
                        sda_down_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.SCL        = scl;
    assign bus.SDA        = sda;
    assign bus.SCL_prev   = scl_p;
    assign bus.SDA_prev   = sda_p;
    assign bus.enable     = enable_q;
    assign bus.rw         = rw_q;
    assign bus.addr_match = addr_match_q;
    assign bus.start_det  = start_det_q;
    assign bus.stop_det   = stop_det_q;
    assign bus.SDA_down   = sda_down_q;
    assign bus.bus_busy   = bus_busy_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_i2c_slave_addr_frontend.sv
// ---------------------------------------------------------------------------
// tb_i2c_slave_addr_frontend
//   Directed bench for the I2C slave address front end (SLAVE_ADDR 7'h42,
//   SYNC_STAGES 2, FILTER_LEN 3). Bus phases are held long enough for the
//   5-cycle pin latency. START/STOP/address-match pulses are checked through
//   an expected-event queue; levels are checked at fixed protocol points.
// ---------------------------------------------------------------------------
module tb_i2c_slave_addr_frontend;

    localparam int H = 8;  // FPGA_clk cycles per bus phase

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ADDR   = 3'd1;
    localparam logic [2:0] ST_ACK    = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_IGNORE = 3'd4;

    localparam int EW = 3;
    localparam logic [EW-1:0] EV_START = 3'b010;
    localparam logic [EW-1:0] EV_STOP  = 3'b100;
    // address match: {2'b11, rw}

    logic FPGA_clk;
    logic rst;

    i2c_slave_addr_frontend_if bus ();

    i2c_slave_addr_frontend #(
        .SLAVE_ADDR (7'h42),
        .SYNC_STAGES(2),
        .FILTER_LEN (3)
    ) dut (
        .FPGA_clk(FPGA_clk),
        .rst     (rst),
        .bus     (bus)
    );

    // ---- clock / reset ----
    initial FPGA_clk = 1'b0;
    always #5 FPGA_clk = ~FPGA_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---- scoreboard ----
    logic [EW-1:0] exp_q[$];
    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_evt(input logic [EW-1:0] got);
        logic [EW-1:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk("event", 32'(got), 32'(exp));
    endtask

    always @(negedge FPGA_clk) begin
        if (rst) begin
            if (bus.start_det)  mon_evt(EV_START);
            if (bus.stop_det)   mon_evt(EV_STOP);
            if (bus.addr_match) mon_evt({2'b11, bus.rw});
        end
    end

    // ---- driver tasks ----
    task automatic wait_clk(input int n);
        repeat (n) @(negedge FPGA_clk);
    endtask

    task automatic bus_start();
        bus.SDA_in = 1'b1; wait_clk(H);
        bus.SCL_in = 1'b1; wait_clk(H);
        exp_q.push_back(EV_START);
        bus.SDA_in = 1'b0; wait_clk(H);
        bus.SCL_in = 1'b0; wait_clk(H);
    endtask

    task automatic bus_stop();
        bus.SDA_in = 1'b0; wait_clk(H);
        bus.SCL_in = 1'b1; wait_clk(H);
        exp_q.push_back(EV_STOP);
        bus.SDA_in = 1'b1; wait_clk(H);
    endtask

    task automatic send_bit(input logic b);
        bus.SDA_in = b;    wait_clk(H);
        bus.SCL_in = 1'b1; wait_clk(H);
        bus.SCL_in = 1'b0; wait_clk(H);
    endtask

    // Address byte plus the ACK clock, checking the ACK window edges.
    task automatic send_addr(input logic [7:0] b, input logic match);
        for (int i = 7; i >= 1; i--) send_bit(b[i]);
        bus.SDA_in = b[0]; wait_clk(H);
        bus.SCL_in = 1'b1; wait_clk(H);
        chk("addr_8th_high_state", 32'(bus.state_dbg), 32'(ST_ADDR));
        chk("addr_8th_high_sda_down", 32'(bus.SDA_down), 32'd0);
        if (match) exp_q.push_back({2'b11, b[0]});
        bus.SCL_in = 1'b0; wait_clk(H);
        chk("addr_8th_fall_state", 32'(bus.state_dbg), match ? 32'(ST_ACK) : 32'(ST_IGNORE));
        chk("addr_8th_fall_sda_down", 32'(bus.SDA_down), 32'(match));
        chk("addr_rw", 32'(bus.rw), 32'(b[0]));
        bus.SDA_in = 1'b1; wait_clk(H);
        bus.SCL_in = 1'b1; wait_clk(H);
        chk("ack_9th_high_sda_down", 32'(bus.SDA_down), 32'(match));
        bus.SCL_in = 1'b0; wait_clk(H);
        chk("ack_9th_fall_sda_down", 32'(bus.SDA_down), 32'd0);
        chk("ack_9th_fall_state", 32'(bus.state_dbg), match ? 32'(ST_ACTIVE) : 32'(ST_IGNORE));
        chk("ack_9th_fall_enable", 32'(bus.enable), 32'(match & ~b[0]));
    endtask

    // ---- directed sequence ----
    initial begin
        logic       sda_min;
        logic [7:0] data_byte;

        rst = 1'b0;
        bus.SCL_in = 1'b1;
        bus.SDA_in = 1'b1;
        bus.data_done = 1'b0;
        wait_clk(3);
        chk("rst_scl",      32'({bus.SCL, bus.SCL_prev, bus.SDA, bus.SDA_prev}), 32'hF);
        chk("rst_flags",    32'({bus.enable, bus.rw, bus.addr_match, bus.start_det,
                                 bus.stop_det, bus.SDA_down, bus.bus_busy}), 32'd0);
        chk("rst_state",    32'(bus.state_dbg), 32'(ST_IDLE));
        rst = 1'b1;
        wait_clk(10);

        // Write to 0x42, one data byte, STOP
        bus_start();
        chk("wr_start_state", 32'(bus.state_dbg), 32'(ST_ADDR));
        chk("wr_start_busy",  32'(bus.bus_busy), 32'd1);
        send_addr(8'h84, 1'b1);
        data_byte = 8'hA5;
        for (int i = 7; i >= 0; i--) send_bit(data_byte[i]);
        chk("wr_data_enable", 32'(bus.enable), 32'd1);
        chk("wr_data_state",  32'(bus.state_dbg), 32'(ST_ACTIVE));
        bus_stop();
        chk("wr_stop_enable", 32'(bus.enable), 32'd0);
        chk("wr_stop_busy",   32'(bus.bus_busy), 32'd0);
        chk("wr_stop_state",  32'(bus.state_dbg), 32'(ST_IDLE));

        // Wrong address 0x43
        bus_start();
        send_addr(8'h86, 1'b0);
        send_bit(1'b0);
        chk("wa_state",  32'(bus.state_dbg), 32'(ST_IGNORE));
        chk("wa_enable", 32'(bus.enable), 32'd0);
        chk("wa_sda_down", 32'(bus.SDA_down), 32'd0);
        bus_stop();
        chk("wa_stop_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("wa_stop_busy",  32'(bus.bus_busy), 32'd0);

        // Read to 0x42, repeated START, write to 0x42, data_done, STOP
        bus_start();
        send_addr(8'h85, 1'b1);
        chk("rd_rw", 32'(bus.rw), 32'd1);
        bus_start();
        chk("rs_state",  32'(bus.state_dbg), 32'(ST_ADDR));
        chk("rs_enable", 32'(bus.enable), 32'd0);
        chk("rs_rw",     32'(bus.rw), 32'd0);
        chk("rs_busy",   32'(bus.bus_busy), 32'd1);
        send_addr(8'h84, 1'b1);
        bus.data_done = 1'b1; wait_clk(1);
        bus.data_done = 1'b0; wait_clk(2);
        chk("dd_state",  32'(bus.state_dbg), 32'(ST_IDLE));
        chk("dd_enable", 32'(bus.enable), 32'd0);
        chk("dd_busy",   32'(bus.bus_busy), 32'd1);
        bus_stop();
        chk("dd_stop_busy", 32'(bus.bus_busy), 32'd0);

        // SDA glitches with SCL high: 2 cycles rejected, 3 cycles accepted
        wait_clk(H);
        sda_min = 1'b1;
        bus.SDA_in = 1'b0; wait_clk(2);
        bus.SDA_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_clk(1);
            sda_min = sda_min & bus.SDA;
        end
        chk("glitch2_sda",   32'(sda_min), 32'd1);
        chk("glitch2_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("glitch2_busy",  32'(bus.bus_busy), 32'd0);
        sda_min = 1'b1;
        exp_q.push_back(EV_START);
        exp_q.push_back(EV_STOP);
        bus.SDA_in = 1'b0; wait_clk(3);
        bus.SDA_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_clk(1);
            sda_min = sda_min & bus.SDA;
        end
        chk("glitch3_sda",   32'(sda_min), 32'd0);
        chk("glitch3_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        chk("glitch3_busy",  32'(bus.bus_busy), 32'd0);

        // Reset while acknowledging
        bus_start();
        exp_q.push_back({2'b11, 1'b0});
        data_byte = 8'h84;
        for (int i = 7; i >= 0; i--) send_bit(data_byte[i]);
        chk("mid_ack_sda_down", 32'(bus.SDA_down), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_ack_rst_sda_down", 32'(bus.SDA_down), 32'd0);
        chk("mid_ack_rst_pins", 32'({bus.SCL, bus.SCL_prev, bus.SDA, bus.SDA_prev}), 32'hF);
        chk("mid_ack_rst_flags", 32'({bus.enable, bus.rw, bus.addr_match, bus.start_det,
                                      bus.stop_det, bus.bus_busy}), 32'd0);
        chk("mid_ack_rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
        bus.SCL_in = 1'b1;
        bus.SDA_in = 1'b1;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(10);
        chk("post_rst_state",    32'(bus.state_dbg), 32'(ST_IDLE));
        chk("post_rst_sda_down", 32'(bus.SDA_down), 32'd0);

        // Normal transaction after reset
        bus_start();
        send_addr(8'h84, 1'b1);
        bus_stop();
        chk("final_busy", 32'(bus.bus_busy), 32'd0);

        wait_clk(5);
        chk("evt_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/i2c_slave_addr_frontend.md
Name: i2c_slave_addr_frontend

Overview:
- Upstream stage of the slave Data In controller.
- Synchronises and glitch-filters the raw SCL/SDA pins, detects START/STOP, shifts in and matches the 7-bit address + R/W byte, and drives the address ACK.
- Hands the conditioned bus signals (SCL, SCL_prev, SDA, SDA_prev) plus `enable` to the Data In controller for the write-data phase.

Parameters:
- SLAVE_ADDR, 7'h42, 7-bit address this slave responds to.
- SYNC_STAGES, 2, flip-flop synchroniser depth per pin (minimum 2).
- FILTER_LEN, 3, consecutive FPGA_clk cycles a synchronised level must persist before the filtered output follows it (minimum 1).

Ports:
- FPGA_clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- SCL_in  input  1  raw SCL pin.
- SDA_in  input  1  raw SDA pin.
- data_done  input  1  single-cycle done pulse from the Data In controller.
- SCL  output  1  filtered SCL.
- SCL_prev  output  1  SCL delayed one FPGA_clk.
- SDA  output  1  filtered SDA.
- SDA_prev  output  1  SDA delayed one FPGA_clk.
- enable  output  1  high while in ACTIVE with rw=0 (write data phase).
- rw  output  1  captured R/W bit (1 = read).
- addr_match  output  1  one-cycle pulse when the address compares equal.
- start_det  output  1  one-cycle pulse on START or repeated START.
- stop_det  output  1  one-cycle pulse on STOP.
- SDA_down  output  1  request to pull SDA low (address ACK).
- bus_busy  output  1  high from START until STOP.

Behaviour:
- Reset (rst=0, asynchronous):
  - SCL, SDA, SCL_prev, SDA_prev, synchroniser and filter flops = 1.
  - All other outputs = 0; state = IDLE; bit counter = 0; shift register = 0.
- Conditioning:
  - Each pin passes through SYNC_STAGES flops, then a filter with a counter.
  - The filter output toggles only after the synchronised value has differed from it for FILTER_LEN consecutive cycles.
  - Any agreeing sample clears the counter.
  - Pin-to-SCL/SDA latency = SYNC_STAGES + FILTER_LEN cycles.
- Edge definitions (on filtered signals):
  - SCL rise = SCL & ~SCL_prev; SCL fall = ~SCL & SCL_prev.
  - START = SCL & SCL_prev & ~SDA & SDA_prev.
  - STOP = SCL & SCL_prev & SDA & ~SDA_prev.
  - start_det / stop_det are registered pulses, asserted the cycle after detection.
- FSM states: IDLE, ADDR, ACK, ACTIVE, IGNORE.
  - IDLE: wait for START -> ADDR; clear bit counter and shift register; bus_busy=1.
  - ADDR: on each SCL rise, shift SDA in MSB-first and increment the 3-bit counter. After the 8th rise (counter wraps 7->0), latch rw = bit0 and compare bits[7:1] with SLAVE_ADDR.
    - On the next SCL fall: match -> addr_match pulse, SDA_down=1, -> ACK.
    - Mismatch -> IGNORE with SDA_down=0.
  - ACK: hold SDA_down=1 through the 9th SCL high. On the following SCL fall, SDA_down=0 -> ACTIVE.
  - ACTIVE: enable = ~rw. Stay until STOP, START or data_done.
  - IGNORE: all control outputs low; wait for STOP or START.
- Priority, every state (highest first):
  - STOP -> IDLE, bus_busy=0, enable=0, SDA_down=0.
  - START (repeated) -> ADDR, counters cleared, rw=0.
  - data_done in ACTIVE -> IDLE; bus_busy stays 1 until STOP.
- STOP and START cannot coincide on filtered signals; if the FSM sees both in the same cycle, STOP wins.
- A STOP or START arriving mid-ADDR aborts the byte; no partial match is reported.
- SDA_down is released within one cycle of STOP or reset.

Test Plan:
- Write to 0x42: START, byte 0x84, ACK clock, SCL toggling -> addr_match pulse; SDA_down=1 from the 8th SCL fall to the 9th SCL fall; rw=0; enable=1; STOP -> enable=0, stop_det pulse, bus_busy=0.
- Wrong address 0x43 (byte 0x86) -> no addr_match; SDA_down stays 0; state IGNORE; enable=0 until STOP.
- Read to 0x42 (byte 0x85) -> ACK given; rw=1; enable=0 in ACTIVE.
- Repeated START in ACTIVE, then byte 0x84 -> start_det pulse; enable drops; ADDR restarts at bit 0; ACK reissued.
- 2-cycle SDA glitch while SCL high (FILTER_LEN=3) -> SDA unchanged; no start_det/stop_det; a 3-cycle pulse is accepted.
- rst asserted mid-ACK with SDA_down=1 -> SDA_down=0 immediately; all flags 0; SCL/SDA/*_prev=1; IDLE after release.
